// File: rtl/ssr_pulse_former.sv
// ssr_pulse_former
//   Forms the SSR interrogation pulse train (P1, P2/SLS, P3) once per
//   interrogation slot. The P1-to-P3 spacing follows the one-hot mode code.
//   Odd interlace slots are staggered by STAGGER clocks before P1.
//
//   Optional feature macro: SSR_SLS_P2_EN
//     defined   - P2 (SLS) is generated and included in tx_gate
//     undefined - P2 is held 0 and the P2 comparator is not built
//
// Ports
//   clk      in   system clock (20 MHz)
//   rst      in   synchronous reset, active low
//   mode     in   [3:0] one-hot mode: 0001=1, 0010=2, 0100=3A, 1000=C, 0000=none
//   oddeven  in   interlace phase of the current slot
//   stop     in   one-cycle end-of-slot tick
//   p1       out  P1 pulse
//   p2       out  P2 (SLS control) pulse
//   p3       out  P3 pulse
//   tx_gate  out  registered OR of the pulses, drives the modulator gate
//   busy     out  train in progress, including the stagger wait
//   done     out  one-cycle tick after the last P3 cycle
//   bad_mode out  one-cycle tick when a trigger sees a non-one-hot mode
module ssr_pulse_former #(
    parameter int unsigned PW      = 16,
    parameter int unsigned P2_OFS  = 40,
    parameter int unsigned D_M1    = 60,
    parameter int unsigned D_M2    = 100,
    parameter int unsigned D_M3A   = 160,
    parameter int unsigned D_MC    = 420,
    parameter int unsigned STAGGER = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] mode,
    input  logic       oddeven,
    input  logic       stop,
    output logic       p1,
    output logic       p2,
    output logic       p3,
    output logic       tx_gate,
    output logic       busy,
    output logic       done,
    output logic       bad_mode
);

    localparam int unsigned CW = 10;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_TRAIN = 2'd2;

    localparam logic [CW-1:0] PW_C       = CW'(PW);
    localparam logic [CW-1:0] STG_LAST_C = CW'(STAGGER - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] dsp_q, dsp_d;
    logic [3:0]    mode_prev_q;
    logic          stop_prev_q;
    logic          p1_q, p3_q, tx_q;
    logic          end_q, done_q, bad_q;

    logic          trig, trig_ok, trig_bad;
    logic          mode_ok;
    logic [CW-1:0] d_sel;
    logic          last;
    logic          in_train;
    logic          p1_n, p2_n, p3_n;

    // First slot triggers when mode leaves 0, later slots the cycle after stop.
    assign trig     = (mode != '0) && ((mode_prev_q == '0) || stop_prev_q);
    assign trig_ok  = trig && mode_ok;
    assign trig_bad = trig && !mode_ok;

    always_comb begin
        mode_ok = 1'b1;
        d_sel   = '0;
        case (mode)
            4'b0001: d_sel = CW'(D_M1);
            4'b0010: d_sel = CW'(D_M2);
            4'b0100: d_sel = CW'(D_M3A);
            4'b1000: d_sel = CW'(D_MC);
            default: mode_ok = 1'b0;
        endcase
    end

    // One counter serves both the stagger wait and the train position.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dsp_d   = dsp_q;
        last    = 1'b0;
        if (trig_ok) begin
            dsp_d   = d_sel;
            cnt_d   = '0;
            state_d = (oddeven && (STAGGER > 0)) ? S_WAIT : S_TRAIN;
        end else if (trig_bad) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == STG_LAST_C) begin
                        state_d = S_TRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_TRAIN: begin
                    if (cnt_q == dsp_q + PW_C - 1'b1) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        last    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Any trigger kills the pulses of the current train on the next cycle.
    assign in_train = (state_q == S_TRAIN) && !trig;
    assign p1_n     = in_train && (cnt_q < PW_C);
    assign p3_n     = in_train && (cnt_q >= dsp_q) && (cnt_q < dsp_q + PW_C);

`ifdef SSR_SLS_P2_EN
    localparam logic [CW-1:0] P2_OFS_C = CW'(P2_OFS);
    logic p2_q;

    assign p2_n = in_train && (cnt_q >= P2_OFS_C) && (cnt_q < P2_OFS_C + PW_C);

    always_ff @(posedge clk) begin
        if (!rst) p2_q <= 1'b0;
        else      p2_q <= p2_n;
    end

    assign p2 = p2_q;
`else
    // P2_OFS is kept in the parameter list so both builds share one interface.
    logic unused_p2_ofs;
    assign unused_p2_ofs = |CW'(P2_OFS);
    assign p2_n          = 1'b0;
    assign p2            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dsp_q       <= '0;
            mode_prev_q <= '0;
            stop_prev_q <= 1'b0;
            p1_q        <= 1'b0;
            p3_q        <= 1'b0;
            tx_q        <= 1'b0;
            end_q       <= 1'b0;
            done_q      <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dsp_q       <= dsp_d;
            mode_prev_q <= mode;
            stop_prev_q <= stop;
            p1_q        <= p1_n;
            p3_q        <= p3_n;
            tx_q        <= p1_n | p2_n | p3_n;
            // done lags the last P3 output by one cycle; an abort in between drops it.
            end_q       <= last;
            done_q      <= end_q && !trig;
            bad_q       <= trig_bad;
        end
    end

    assign p1       = p1_q;
    assign p3       = p3_q;
    assign tx_gate  = tx_q;
    assign busy     = (state_q != S_IDLE) || end_q;
    assign done     = done_q;
    assign bad_mode = bad_q;

endmodule
